sha_1_stream_core: RTL and testbench

Parametrised SHA-1 compression engine that hashes messages of any number of 512-bit blocks, successor to the fixed single-block `sha_1_core`. Blocks are accepted over a valid/ready handshake and chained through an internal hash state, with a selectable round throughput (rounds per clock). It sits between a padding/block-assembly front end and any digest consumer. The digest is registered and flagged once per message.

---
 rtl/sha_1_stream_core.sv | 145 ++++++++++++++
 tb/tb_sha_1_stream_core.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sha_1_stream_core.sv
// SHA-1 compression engine for multi-block messages: blocks arrive over valid/ready,
// chain through the H state, and the digest is registered once per message.
module sha_1_stream_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         block_valid,
   output logic         block_ready,
   input  logic         block_first,
   input  logic         block_last,
   input  logic [511:0] block_data,
   output logic         busy,
   output logic [159:0] digest,
   output logic         digest_valid
);
   localparam int R = ROUNDS_PER_CYCLE;

   generate
      if (!(R == 1 || R == 2 || R == 4 || R == 5)) begin : g_bad_rounds
         $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
      end
   endgenerate

   localparam logic [159:0] H_INIT = {32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                      32'h10325476, 32'hc3d2e1f0};

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   state_t           state_q, state_d;
   logic [159:0]     h_q, h_d;
   logic [31:0]      a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d;
   logic [15:0][31:0] w_q, w_d;
   logic [6:0]       t_q, t_d;
   logic             last_q, last_d;
   logic [159:0]     digest_q, digest_d;
   logic             digest_valid_q, digest_valid_d;
   logic             accept;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ROUND;
         ROUND:   if (t_q + 7'(R) == 7'd80) state_d = FINAL;
         FINAL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      block_ready = (state_q == IDLE) && !reset;
      busy        = (state_q != IDLE);
   end

   assign accept       = block_valid && block_ready;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;

   always_comb begin : p_datapath
      logic [31:0] ext [0:15+R];
      logic [31:0] ca, cb, cc, cd, ce, f, k, tmp;
      logic [6:0]  tt;

      h_d = h_q;  a_d = a_q;  b_d = b_q;  c_d = c_q;  d_d = d_q;  e_d = e_q;
      w_d = w_q;  t_d = t_q;  last_d = last_q;
      digest_d = digest_q;  digest_valid_d = 1'b0;

      // ext[i] = W[t+i]; the top R entries are the freshly scheduled words
      for (int i = 0; i < 16; i++) ext[i] = w_q[i];
      for (int i = 16; i < 16 + R; i++)
         ext[i] = rotl(ext[i-3] ^ ext[i-8] ^ ext[i-14] ^ ext[i-16], 1);

      ca = a_q;  cb = b_q;  cc = c_q;  cd = d_q;  ce = e_q;
      for (int i = 0; i < R; i++) begin
         tt = t_q + 7'(i);
         if (tt < 7'd20) begin
            f = (cb & cc) | (~cb & cd);            k = 32'h5a827999;
         end else if (tt < 7'd40) begin
            f = cb ^ cc ^ cd;                      k = 32'h6ed9eba1;
         end else if (tt < 7'd60) begin
            f = (cb & cc) | (cb & cd) | (cc & cd); k = 32'h8f1bbcdc;
         end else begin
            f = cb ^ cc ^ cd;                      k = 32'hca62c1d6;
         end
         tmp = rotl(ca, 5) + f + ce + k + ext[i];
         ce = cd;  cd = cc;  cc = rotl(cb, 30);  cb = ca;  ca = tmp;
      end

      case (state_q)
         IDLE: if (accept) begin
            for (int i = 0; i < 16; i++) w_d[i] = block_data[511-32*i -: 32];
            if (block_first) h_d = H_INIT;
            {a_d, b_d, c_d, d_d, e_d} = block_first ? H_INIT : h_q;
            last_d = block_last;
            t_d    = '0;
         end
         ROUND: begin
            {a_d, b_d, c_d, d_d, e_d} = {ca, cb, cc, cd, ce};
            for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];
            t_d = t_q + 7'(R);
         end
         FINAL: begin
            h_d = {h_q[159:128] + a_q, h_q[127:96] + b_q, h_q[95:64] + c_q,
                   h_q[63:32] + d_q, h_q[31:0] + e_q};
            if (last_q) begin
               digest_d       = h_d;
               digest_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= H_INIT;
         a_q <= '0;  b_q <= '0;  c_q <= '0;  d_q <= '0;  e_q <= '0;
         w_q <= '0;
         t_q <= '0;
         last_q <= 1'b0;
         digest_q <= '0;
         digest_valid_q <= 1'b0;
      end else begin
         h_q <= h_d;
         a_q <= a_d;  b_q <= b_d;  c_q <= c_d;  d_q <= d_d;  e_q <= e_d;
         w_q <= w_d;
         t_q <= t_d;
         last_q <= last_d;
         digest_q <= digest_d;
         digest_valid_q <= digest_valid_d;
      end
   end
endmodule

// File: tb/tb_sha_1_stream_core.sv
// Directed bench for sha_1_stream_core: known SHA-1 vectors on R=1, R=4 and R=5 builds,
// plus handshake timing, digest hold, mid-message reset and message restart.
module tb_sha_1_stream_core;
   logic         clk = 1'b0;
   logic         reset;
   logic         vld [3];
   logic         rdy [3];
   logic         bsy [3];
   logic         dv  [3];
   logic [159:0] dg  [3];
   logic         bfirst, blast;
   logic [511:0] bdata;

   int cyc = 0;
   int p0  = 0;
   int nvec = 0;
   int nmis = 0;

   localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
   localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

   logic [511:0] blk_abc, blk_empty, blk_m1, blk_m2;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dv[0]) p0 <= p0 + 1;
   end

   sha_1_stream_core #(.ROUNDS_PER_CYCLE(1)) u_r1 (
      .clk(clk), .reset(reset), .block_valid(vld[0]), .block_ready(rdy[0]),
      .block_first(bfirst), .block_last(blast), .block_data(bdata),
      .busy(bsy[0]), .digest(dg[0]), .digest_valid(dv[0]));
   sha_1_stream_core #(.ROUNDS_PER_CYCLE(4)) u_r4 (
      .clk(clk), .reset(reset), .block_valid(vld[1]), .block_ready(rdy[1]),
      .block_first(bfirst), .block_last(blast), .block_data(bdata),
      .busy(bsy[1]), .digest(dg[1]), .digest_valid(dv[1]));
   sha_1_stream_core #(.ROUNDS_PER_CYCLE(5)) u_r5 (
      .clk(clk), .reset(reset), .block_valid(vld[2]), .block_ready(rdy[2]),
      .block_first(bfirst), .block_last(blast), .block_data(bdata),
      .busy(bsy[2]), .digest(dg[2]), .digest_valid(dv[2]));

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Offer a block to DUT s; acc is the cycle stamp of the accepting edge.
   task automatic send(input int s, input logic [511:0] d, input logic f, input logic l,
                       input bit hold, output int acc);
      bit r;
      @(negedge clk);
      bdata = d;  bfirst = f;  blast = l;  vld[s] = 1'b1;
      acc = -1;
      for (int n = 0; n < 300; n++) begin
         r = rdy[s];
         @(posedge clk);
         #1;
         if (r) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) chk("accept_timeout", 0, 1);
      if (!hold) vld[s] = 1'b0;
   endtask

   // lat: edges from accept until digest_valid is seen; bc: cycles with busy high.
   task automatic wait_dv(input int s, input int acc, output int lat, output int bc);
      lat = -1;
      bc  = bsy[s] ? 1 : 0;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         #1;
         if (dv[s]) begin
            lat = cyc - acc;
            break;
         end
         if (bsy[s]) bc++;
      end
      if (lat < 0) chk("dv_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int acc, acc2, lat, bc, p;
      blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
      blk_empty = {32'h80000000, 480'h0};
      blk_m1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      blk_m2    = {480'h0, 32'h000001c0};
      reset = 1'b1;
      for (int i = 0; i < 3; i++) vld[i] = 1'b0;
      bfirst = 1'b0;  blast = 1'b0;  bdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", rdy[0], 0);
      chk("rst_busy", bsy[0], 0);
      chk("rst_digest", dg[0], 0);
      chk("rst_dv", dv[0], 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", rdy[0], 1);

      // single block "abc", R=1
      p = p0;
      send(0, blk_abc, 1, 1, 0, acc);
      wait_dv(0, acc, lat, bc);
      chk("abc_digest", dg[0], D_ABC);
      chk("r1_dv_latency", lat, 81);
      chk("r1_busy_cycles", bc, 81);
      idle(3);
      chk("abc_pulses", p0 - p, 1);
      chk("dv_one_cycle", dv[0], 0);

      send(0, blk_empty, 1, 1, 0, acc);
      wait_dv(0, acc, lat, bc);
      chk("empty_digest", dg[0], D_EMPTY);

      // two-block message, valid held across both offers
      idle(2);
      p = p0;
      send(0, blk_m1, 1, 0, 1, acc);
      send(0, blk_m2, 0, 1, 0, acc2);
      chk("b2b_period", acc2 - acc, 82);
      chk("digest_held_nonlast", dg[0], D_EMPTY);
      wait_dv(0, acc2, lat, bc);
      chk("two_block_digest", dg[0], D_TWO);
      chk("two_block_latency", lat, 81);
      idle(3);
      chk("two_block_pulses", p0 - p, 1);

      // wider round throughput
      send(1, blk_abc, 1, 1, 0, acc);
      wait_dv(1, acc, lat, bc);
      chk("r4_digest", dg[1], D_ABC);
      chk("r4_dv_latency", lat, 21);
      chk("r4_busy_cycles", bc, 21);
      send(2, blk_abc, 1, 1, 0, acc);
      wait_dv(2, acc, lat, bc);
      chk("r5_digest", dg[2], D_ABC);
      chk("r5_dv_latency", lat, 17);
      chk("r5_busy_cycles", bc, 17);

      // reset in the middle of block 1; next block uses first=0 and must chain from H0
      p = p0;
      send(0, blk_m1, 1, 0, 0, acc);
      idle(40);
      chk("abort_busy_before", bsy[0], 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready", rdy[0], 0);
      chk("abort_busy", bsy[0], 0);
      chk("abort_digest", dg[0], 0);
      reset = 1'b0;
      send(0, blk_abc, 0, 1, 0, acc);
      wait_dv(0, acc, lat, bc);
      chk("after_abort_digest", dg[0], D_ABC);
      idle(3);
      chk("abort_pulses", p0 - p, 1);

      // partial message abandoned by a new first block
      send(0, blk_empty, 1, 1, 0, acc);
      wait_dv(0, acc, lat, bc);
      idle(2);
      p = p0;
      send(0, blk_m1, 1, 0, 0, acc);
      send(0, blk_abc, 1, 1, 0, acc2);
      chk("partial_digest_held", dg[0], D_EMPTY);
      wait_dv(0, acc2, lat, bc);
      chk("restart_digest", dg[0], D_ABC);
      idle(3);
      chk("restart_pulses", p0 - p, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
